// File: rtl/reg_file_v2.sv
// Parametrised register file: wide rs read, narrow rt/rd port pair, load writeback port, handshaked dump engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_v2 #(
    parameter int W      = 9,
    parameter int DEPTH  = 16,
    parameter int NARROW = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int NW     = $clog2(NARROW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic [AW-1:0] rs_addr,
    input  logic [NW-1:0] rt_addr,
    input  logic [NW-1:0] rd_addr,
    input  logic [W-1:0]  rd_in,
    input  logic          ld_write,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_in,
    output logic [W-1:0]  rs_out,
    output logic [W-1:0]  rt_out,
    output logic          ld_drop,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [W-1:0]  dump_data,
    output logic          dump_done
);

    typedef enum logic {
        IDLE,
        SCAN
    } dump_state_t;

    logic [W-1:0]  regs [DEPTH];
    logic [AW-1:0] rd_target;
    logic [AW-1:0] rt_target;
    logic          collision;

    dump_state_t   state;
    dump_state_t   state_next;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] addr_inc;
    logic [W-1:0]  data_next;
    logic          done_next;
    logic          last_beat;

    assign rd_target = AW'(rd_addr);
    assign rt_target = AW'(rt_addr);
    assign collision = write && ld_write && (rd_target == ld_addr);

    // rd has priority on a shared target; the losing load is flagged one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            ld_drop <= 1'b0;
        end else begin
            if (ld_write && !collision) begin
                regs[ld_addr] <= ld_in;
            end
            if (write) begin
                regs[rd_target] <= rd_in;
            end
            ld_drop <= collision;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        rs_out = regs[rs_addr];
        if (write && (rd_target == rs_addr)) begin
            rs_out = rd_in;
        end else if (ld_write && (ld_addr == rs_addr)) begin
            rs_out = ld_in;
        end

        rt_out = regs[rt_target];
        if (write && (rd_target == rt_target)) begin
            rt_out = rd_in;
        end else if (ld_write && (ld_addr == rt_target)) begin
            rt_out = ld_in;
        end
    end
`else
    assign rs_out = regs[rs_addr];
    assign rt_out = regs[rt_target];
`endif

    assign addr_inc   = dump_addr + AW'(1);
    assign last_beat  = (dump_addr == AW'(DEPTH - 1));
    assign dump_valid = (state == SCAN);

    // Dump data is captured from the stored array, so a stalled beat never changes underneath the consumer
    always_comb begin
        state_next = state;
        addr_next  = dump_addr;
        data_next  = dump_data;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = SCAN;
                    addr_next  = '0;
                    data_next  = regs[0];
                end
            end
            SCAN: begin
                if (dump_ready) begin
                    if (last_beat) begin
                        state_next = IDLE;
                        addr_next  = '0;
                        done_next  = 1'b1;
                    end else begin
                        addr_next = addr_inc;
                        data_next = regs[addr_inc];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dump_addr <= '0;
            dump_data <= '0;
            dump_done <= 1'b0;
        end else begin
            state     <= state_next;
            dump_addr <= addr_next;
            dump_data <= data_next;
            dump_done <= done_next;
        end
    end

endmodule

// File: tb/tb_reg_file_v2.sv
// Directed self-checking bench for reg_file_v2 with hand-computed expected values.
module tb_reg_file_v2;

    localparam int W     = 9;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write;
    logic [AW-1:0] rs_addr;
    logic [NW-1:0] rt_addr;
    logic [NW-1:0] rd_addr;
    logic [W-1:0]  rd_in;
    logic          ld_write;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_in;
    logic [W-1:0]  rs_out;
    logic [W-1:0]  rt_out;
    logic          ld_drop;
    logic          dump_start;
    logic          dump_ready;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [W-1:0]  dump_data;
    logic          dump_done;

    int checks = 0;
    int errors = 0;

    reg_file_v2 #(.W(W), .DEPTH(DEPTH), .NARROW(4)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_in(rd_in),
        .ld_write(ld_write), .ld_addr(ld_addr), .ld_in(ld_in),
        .rs_out(rs_out), .rt_out(rt_out), .ld_drop(ld_drop),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [NW-1:0] rda, input logic [W-1:0] rdd,
                                 input logic lw, input logic [AW-1:0] lda, input logic [W-1:0] ldd);
        write    = wr;
        rd_addr  = rda;
        rd_in    = rdd;
        ld_write = lw;
        ld_addr  = lda;
        ld_in    = ldd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int exp_idx;

        rst_n      = 1'b0;
        rs_addr    = '0;
        rt_addr    = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        checkOutput("reset dump_valid", 32'(dump_valid), 32'd0);
        checkOutput("reset dump_addr", 32'(dump_addr), 32'd0);
        checkOutput("reset dump_data", 32'(dump_data), 32'd0);
        checkOutput("reset dump_done", 32'(dump_done), 32'd0);
        checkOutput("reset ld_drop", 32'(ld_drop), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rs_addr = AW'(i);
            #1;
            checkOutput($sformatf("reset rs_out[%0d]", i), 32'(rs_out), 32'd0);
        end
        checkOutput("reset rt_out", 32'(rt_out), 32'd0);

        // rd write to reg 3, same-cycle read then next-cycle read
        applyStimulus(1'b1, 2'd3, 9'd255, 1'b0, 4'd0, 9'd0);
        rs_addr = 4'd3;
        rt_addr = 2'd3;
        #1;
`ifdef REG_FILE_BYPASS_EN
        checkOutput("same-cycle rs_out", 32'(rs_out), 32'd255);
`else
        checkOutput("same-cycle rs_out", 32'(rs_out), 32'd0);
`endif
        tick();
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        #1;
        checkOutput("rd write rs_out", 32'(rs_out), 32'd255);
        checkOutput("rd write rt_out", 32'(rt_out), 32'd255);

        // load writeback to reg 8
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b1, 4'd8, 9'h1AA);
        tick();
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        rs_addr = 4'd8;
        rt_addr = 2'd0;
        #1;
        checkOutput("ld write rs_out", 32'(rs_out), 32'h1AA);
        checkOutput("ld write rt_out reg0", 32'(rt_out), 32'd0);
        checkOutput("ld write no drop", 32'(ld_drop), 32'd0);

        // collision on reg 2
        applyStimulus(1'b1, 2'd2, 9'd5, 1'b1, 4'd2, 9'd7);
        tick();
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        rs_addr = 4'd2;
        #1;
        checkOutput("collision rs_out", 32'(rs_out), 32'd5);
        checkOutput("collision ld_drop", 32'(ld_drop), 32'd1);
        tick();
        checkOutput("collision ld_drop clear", 32'(ld_drop), 32'd0);

        // distinct targets both land
        applyStimulus(1'b1, 2'd1, 9'd11, 1'b1, 4'd9, 9'd22);
        tick();
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        rs_addr = 4'd9;
        rt_addr = 2'd1;
        #1;
        checkOutput("dual write rs_out", 32'(rs_out), 32'd22);
        checkOutput("dual write rt_out", 32'(rt_out), 32'd11);
        checkOutput("dual write no drop", 32'(ld_drop), 32'd0);

        // preload reg[i] = i + 16
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 2'd0, 9'd0, 1'b1, AW'(i), W'(i + 16));
            tick();
        end
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);

        // full-speed dump
        dump_start = 1'b1;
        dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput($sformatf("fast beat %0d valid", k), 32'(dump_valid), 32'd1);
            checkOutput($sformatf("fast beat %0d addr", k), 32'(dump_addr), 32'(k));
            checkOutput($sformatf("fast beat %0d data", k), 32'(dump_data), 32'(k + 16));
            checkOutput($sformatf("fast beat %0d done", k), 32'(dump_done), 32'd0);
            tick();
        end
        checkOutput("fast end valid", 32'(dump_valid), 32'd0);
        checkOutput("fast end done", 32'(dump_done), 32'd1);
        checkOutput("fast end addr", 32'(dump_addr), 32'd0);
        tick();
        checkOutput("fast done pulse", 32'(dump_done), 32'd0);

        // throttled dump with a write to reg 4 while beat 4 stalls
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        cyc = 0;
        exp_idx = 0;
        while (dump_valid && cyc < 100) begin
            dump_ready = cyc[0];
            if (exp_idx == 4 && !dump_ready) begin
                applyStimulus(1'b0, 2'd0, 9'd0, 1'b1, 4'd4, 9'd99);
            end else begin
                applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
            end
            #1;
            checkOutput($sformatf("slow cyc %0d addr", cyc), 32'(dump_addr), 32'(exp_idx));
            checkOutput($sformatf("slow cyc %0d data", cyc), 32'(dump_data), 32'(exp_idx + 16));
            tick();
            cyc++;
            if (dump_ready) begin
                exp_idx++;
            end
        end
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        checkOutput("slow cycle count", 32'(cyc), 32'd32);
        checkOutput("slow end done", 32'(dump_done), 32'd1);
        rs_addr = 4'd4;
        #1;
        checkOutput("stall write landed", 32'(rs_out), 32'd99);
        tick();

        // reset during beat 7 aborts the dump and drops the reset-cycle write
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        checkOutput("abort beat addr", 32'(dump_addr), 32'd7);
        checkOutput("abort beat data", 32'(dump_data), 32'd23);
        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b1, 4'd10, 9'd33);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 9'd0, 1'b0, 4'd0, 9'd0);
        rs_addr = 4'd10;
        #1;
        checkOutput("abort valid", 32'(dump_valid), 32'd0);
        checkOutput("abort done", 32'(dump_done), 32'd0);
        checkOutput("abort addr", 32'(dump_addr), 32'd0);
        checkOutput("reset-cycle write dropped", 32'(rs_out), 32'd0);
        rs_addr = 4'd5;
        #1;
        checkOutput("abort reg5 cleared", 32'(rs_out), 32'd0);
        tick();
        checkOutput("abort no late done", 32'(dump_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_v2.md
# reg_file_v2

Parametrised second-generation register file for the emulator datapath: one wide-window read port (rs), one narrow-window read/write port pair (rt/rd), a second full-range write port for load writeback, and a handshaked debug dump engine that walks every register in order. Sits between decode and the ALU/load unit, replacing the fixed 9-bit, 16-entry file. The dump port feeds the trace/compare logic of the emulator harness.

## Interface
- W, 9, data width in bits
- DEPTH, 16, number of registers; power of two, ≥ 4
- NARROW, 4, registers reachable by rt/rd (indices 0..NARROW-1); power of two, ≤ DEPTH
- AW, $clog2(DEPTH), derived; NW, $clog2(NARROW), derived
---
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- write  in  1  rd write enable
- rs_addr  in  AW  wide read address
- rt_addr  in  NW  narrow read address
- rd_addr  in  NW  narrow write address
- rd_in  in  W  rd write data
- ld_write  in  1  load-writeback enable
- ld_addr  in  AW  load-writeback address
- ld_in  in  W  load-writeback data
- rs_out  out  W  reg[rs_addr], combinational
- rt_out  out  W  reg[rt_addr], combinational
- ld_drop  out  1  registered; 1 for one cycle after a dropped load write
- dump_start  in  1  request a full dump (level, sampled in IDLE only)
- dump_ready  in  1  consumer accepts current dump beat
- dump_valid  out  1  dump beat present
- dump_addr  out  AW  index of current beat
- dump_data  out  W  captured contents of reg[dump_addr]
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Storage: DEPTH × W flops. Writes on rising clk edge; reads combinational.
- rd write: write=1 stores rd_in into reg[{0, rd_addr}] (zero-extended to AW).
- ld write: ld_write=1 stores ld_in into reg[ld_addr].
- Collision: write=1, ld_write=1, same target → rd_in wins, ld discarded, ld_drop=1 next cycle. Different targets → both written.
- Dump FSM, states IDLE, SCAN:
  - IDLE: dump_valid=0. dump_start=1 at edge → SCAN, dump_addr=0, dump_data=reg[0] as held before that edge (same-edge writes not included).
  - SCAN: dump_valid=1; dump_addr/dump_data held stable while dump_ready=0, even if reg[dump_addr] is written.
  - SCAN, dump_ready=1, dump_addr<DEPTH-1 → dump_addr+1, dump_data=reg[dump_addr+1] pre-edge value.
  - SCAN, dump_ready=1, dump_addr=DEPTH-1 → IDLE, dump_addr=0, dump_done=1 for one cycle.
  - dump_start ignored in SCAN; dump_start held high re-triggers from IDLE on the cycle after dump_done.
- Dump never blocks or delays register writes or reads.

## Timing
- Reset (rst_n=0 at edge): all registers 0, FSM IDLE, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0, ld_drop=0; rs_out/rt_out read 0 thereafter. Writes in reset cycle are discarded.
- Reset mid-SCAN: aborts dump, no dump_done.
- Write-to-read latency: 1 cycle (value visible on rs_out/rt_out after the edge), 0 with bypass (see Configuration).
- Dump throughput: one beat per cycle with dump_ready held high; full dump = DEPTH cycles in SCAN.
- ld_drop: asserted the cycle after the collision edge, cleared next edge unless another collision.

## Configuration
- REG_FILE_BYPASS_EN defined: rs_out/rt_out forward write data of the same cycle when read address matches an active write target; rd_in has priority over ld_in on double match. Dump capture is not bypassed.
- Undefined: reads return stored contents only; pure flop-array read.

## Test plan
- Reset, then rs_addr sweep 0..15 → rs_out=0 for all; dump_valid=0.
- write=1, rd_addr=3, rd_in=255; next cycle rs_addr=3, rt_addr=3 → both 255; without macro, same-cycle rs_out=0, with REG_FILE_BYPASS_EN same-cycle rs_out=255.
- ld_write=1, ld_addr=8, ld_in=0x1AA; next cycle rs_addr=8 → 0x1AA; rt_addr cannot reach 8.
- write=1 rd_addr=2 rd_in=5 with ld_write=1 ld_addr=2 ld_in=7 → reg[2]=5, ld_drop=1 for exactly one cycle.
- Preload reg[i]=i+16, dump_start=1, dump_ready=1 → 16 beats addr 0..15, data 16..31, dump_done one cycle after beat 15; with dump_ready toggling every other cycle, beats held stable, 32 cycles total; write reg[4]=99 while beat 4 stalled → beat 4 still shows 20.
- rst_n=0 during beat 7 → dump_valid=0 next cycle, no dump_done, registers cleared.
